vshift_seq: RTL and testbench

- Sequencer that executes one vector shift instruction (SLL/SRL/SRA) element by element through the lane's single shared arithmetic shifter.
- Accepts an instruction over a valid/ready handshake and reads operand pairs from the lane register file, one element per cycle.
- Converts each element's shift amount to the shifter's signed-shift encoding and drives the shifter's clock-gate enable.
- Returns results over a valid/ready writeback port and pulses done_o on completion.

---
 rtl/vshift_seq.sv | 176 +++++++++++++++++
 tb/tb_vshift_seq.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vshift_seq.sv
// Purpose: runs one vector SLL/SRL/SRA element by element through the lane's shared shifter.
//          VSHIFT_MASK_EN adds the req_mask_i port so masked-off elements are skipped.
// Latency: accept at t, first read at t+1, first writeback at t+2; 1 element/cycle. Backpressure: a held writeback stalls reads.
module vshift_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_VL     = 16,
    parameter int VL_W       = $clog2(MAX_VL + 1)
) (
    input  logic                  module_clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [1:0]            req_op_i,
    input  logic [VL_W-1:0]       req_vl_i,
`ifdef VSHIFT_MASK_EN
    input  logic [MAX_VL-1:0]     req_mask_i,
`endif
    output logic                  rd_en_o,
    output logic [VL_W-1:0]       rd_idx_o,
    input  logic [DATA_WIDTH-1:0] rd_a_i,
    input  logic [DATA_WIDTH-1:0] rd_sh_i,
    output logic                  sh_en_o,
    output logic                  sh_dir_sel_o,
    output logic                  sh_data_tc_o,
    output logic [DATA_WIDTH-1:0] sh_a_o,
    output logic [DATA_WIDTH-1:0] sh_shift_o,
    input  logic [DATA_WIDTH-1:0] sh_result_i,
    output logic                  wb_valid_o,
    input  logic                  wb_ready_i,
    output logic [VL_W-1:0]       wb_idx_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int SHW = $clog2(DATA_WIDTH);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            op_q;
    logic [VL_W-1:0]       vl_q;
    logic [VL_W-1:0]       idx_q;
    logic [VL_W-1:0]       idx_nxt;
    logic                  err_q;
    logic                  wb_valid_q;
    logic [VL_W-1:0]       wb_idx_q;
    logic [DATA_WIDTH-1:0] wb_data_q;
`ifdef VSHIFT_MASK_EN
    logic [MAX_VL-1:0]     mask_q;
`endif

    logic                  accept;
    logic                  in_range;
    logic                  stall;
    logic                  elem_on;
    logic                  issue;
    logic                  skip;
    logic                  advance;
    logic                  last;
    logic [DATA_WIDTH-1:0] shamt;
    logic                  unused_sh_hi;

    assign accept   = req_valid_i && (state_q == S_IDLE);
    assign in_range = (state_q == S_RUN) && (idx_q < vl_q);
    assign stall    = wb_valid_q && !wb_ready_i;
    assign idx_nxt  = idx_q + 1'b1;
    assign last     = (idx_nxt == vl_q);

    always_comb begin
        elem_on = 1'b1;
`ifdef VSHIFT_MASK_EN
        elem_on = 1'b0;
        for (int i = 0; i < MAX_VL; i++) begin
            if (idx_q == VL_W'(i)) elem_on = mask_q[i];
        end
`endif
    end

    // Masked-off elements advance even while the writeback is stalled.
    assign issue   = in_range && elem_on && !stall;
    assign skip    = in_range && !elem_on;
    assign advance = issue || skip;

    // Right shifts are expressed to the shifter as a negative shift amount.
    assign shamt        = {{(DATA_WIDTH - SHW){1'b0}}, rd_sh_i[SHW-1:0]};
    assign unused_sh_hi = ^rd_sh_i[DATA_WIDTH-1:SHW];
    assign sh_shift_o   = (op_q == OP_SLL) ? shamt : (~shamt + 1'b1);
    assign sh_dir_sel_o = (op_q == OP_SRL) || (op_q == OP_SRA);
    assign sh_data_tc_o = (op_q == OP_SRA);
    assign sh_a_o       = rd_a_i;
    assign sh_en_o      = issue;

    assign rd_en_o  = issue;
    assign rd_idx_o = idx_q;

    assign req_ready_o = (state_q == S_IDLE);
    assign wb_valid_o  = wb_valid_q;
    assign wb_idx_o    = wb_idx_q;
    assign wb_data_o   = wb_data_q;
    assign done_o      = (state_q == S_DONE);
    assign err_o       = (state_q == S_DONE) && err_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    if ((req_vl_i == '0) || (req_op_i == OP_RSV)) state_d = S_DONE;
                    else                                          state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (advance && last) begin
                    // A skipped last element needs no drain if nothing is left pending.
                    if (issue)                            state_d = S_DRAIN;
                    else if (!wb_valid_q || wb_ready_i)   state_d = S_DONE;
                    else                                  state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!wb_valid_q || wb_ready_i) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge module_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            op_q       <= OP_SLL;
            vl_q       <= '0;
            idx_q      <= '0;
            err_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_idx_q   <= '0;
            wb_data_q  <= '0;
`ifdef VSHIFT_MASK_EN
            mask_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= req_op_i;
                vl_q  <= req_vl_i;
                idx_q <= '0;
                err_q <= (req_op_i == OP_RSV);
`ifdef VSHIFT_MASK_EN
                mask_q <= req_mask_i;
`endif
            end else if (advance) begin
                idx_q <= idx_nxt;
            end

            if (issue) begin
                wb_valid_q <= 1'b1;
                wb_idx_q   <= idx_q;
                wb_data_q  <= sh_result_i;
            end else if (wb_ready_i) begin
                wb_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vshift_seq.sv
// Bench for vshift_seq: table of single-element vectors plus multi-cycle sequences, scoreboard on writebacks.
module tb_vshift_seq;

    localparam int DW  = 32;
    localparam int MVL = 16;
    localparam int VW  = 5;

    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] SRA = 2'b10;
    localparam logic [1:0] RSV = 2'b11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'b00;
    logic [VW-1:0] req_vl = '0;
    logic [MVL-1:0] req_mask = '1;
    logic          rd_en;
    logic [VW-1:0] rd_idx;
    logic [DW-1:0] rd_a, rd_sh;
    logic          sh_en, sh_dir_sel, sh_data_tc;
    logic [DW-1:0] sh_a, sh_shift, sh_result;
    logic          wb_valid;
    logic          wb_ready = 1'b1;
    logic [VW-1:0] wb_idx;
    logic [DW-1:0] wb_data;
    logic          done, err;

    always #5 clk = ~clk;

    vshift_seq #(.DATA_WIDTH(DW), .MAX_VL(MVL), .VL_W(VW)) dut (
        .module_clk_i (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_vl_i     (req_vl),
`ifdef VSHIFT_MASK_EN
        .req_mask_i   (req_mask),
`endif
        .rd_en_o      (rd_en),
        .rd_idx_o     (rd_idx),
        .rd_a_i       (rd_a),
        .rd_sh_i      (rd_sh),
        .sh_en_o      (sh_en),
        .sh_dir_sel_o (sh_dir_sel),
        .sh_data_tc_o (sh_data_tc),
        .sh_a_o       (sh_a),
        .sh_shift_o   (sh_shift),
        .sh_result_i  (sh_result),
        .wb_valid_o   (wb_valid),
        .wb_ready_i   (wb_ready),
        .wb_idx_o     (wb_idx),
        .wb_data_o    (wb_data),
        .done_o       (done),
        .err_o        (err)
    );

    // Register file and shifter models.
    logic [DW-1:0] a_mem  [MVL];
    logic [DW-1:0] sh_mem [MVL];
    assign rd_a  = a_mem[rd_idx[3:0]];
    assign rd_sh = sh_mem[rd_idx[3:0]];

    always_comb begin
        logic [DW-1:0] neg;
        neg = ~sh_shift + 1'b1;
        if (!sh_dir_sel)     sh_result = sh_a << sh_shift;
        else if (sh_data_tc) sh_result = $unsigned($signed(sh_a) >>> neg);
        else                 sh_result = sh_a >> neg;
    end

    function automatic logic [DW-1:0] model(input logic [1:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] sh);
        logic [4:0] s;
        s = sh[4:0];
        case (op)
            SLL:     model = a << s;
            SRL:     model = a >> s;
            SRA:     model = $unsigned($signed(a) >>> s);
            default: model = a;
        endcase
    endfunction

    typedef struct {
        logic [VW-1:0] idx;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [1:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] sh;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t tbl[11];

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0, err_cnt = 0, acc_cnt = 0, cyc = 0;
    int last_acc_cyc = 0, done_cyc = 0;
    logic          prev_stall = 1'b0;
    logic [VW-1:0] prev_idx = '0;
    logic [DW-1:0] prev_data = '0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Writeback monitor and stall invariants, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst_n) begin
            if (prev_stall) begin
                chk("hold_valid", wb_valid, 1);
                chk("hold_idx", wb_idx, prev_idx);
                chk("hold_data", wb_data, prev_data);
            end
            if (wb_valid && !wb_ready) begin
                chk("stall_rd_en", rd_en, 0);
                chk("stall_sh_en", sh_en, 0);
            end
            if (wb_valid && wb_ready) begin
                acc_cnt++;
                last_acc_cyc = cyc;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL wb_unexpected: got idx %0d data 0x%08h, expected no writeback", wb_idx, wb_data);
                end else begin
                    e = sb.pop_front();
                    chk("wb_idx", wb_idx, e.idx);
                    chk("wb_data", wb_data, e.data);
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (err) err_cnt++;
            prev_stall = wb_valid && !wb_ready;
            prev_idx   = wb_idx;
            prev_data  = wb_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic push_exp(input logic [1:0] op, input int vl, input logic [MVL-1:0] mask);
        for (int i = 0; i < vl; i++) begin
            if (mask[i]) sb.push_back('{idx: VW'(i), data: model(op, a_mem[i], sh_mem[i])});
        end
    endtask

    task automatic send(input logic [1:0] op, input int vl, input logic [MVL-1:0] mask);
        @(negedge clk);
        req_op    = op;
        req_vl    = VW'(vl);
        req_mask  = mask;
        req_valid = 1'b1;
        chk("req_ready_idle", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done) break;
        end
        if (k == 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: no done_o within 200 cycles, expected done_o = 1", name);
        end
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int d0, a0, e0;
        tbl[0]  = '{SLL, 32'h0000_0001, 32'd0,         32'h0000_0001};
        tbl[1]  = '{SLL, 32'h0000_0001, 32'd1,         32'h0000_0002};
        tbl[2]  = '{SLL, 32'h0000_0001, 32'd33,        32'h0000_0002};
        tbl[3]  = '{SLL, 32'h0000_0001, 32'd31,        32'h8000_0000};
        tbl[4]  = '{SRL, 32'h8000_0000, 32'd31,        32'h0000_0001};
        tbl[5]  = '{SRL, 32'hF0F0_F0F0, 32'd4,         32'h0F0F_0F0F};
        tbl[6]  = '{SRA, 32'hF0F0_F0F0, 32'd4,         32'hFF0F_0F0F};
        tbl[7]  = '{SRA, 32'h7FFF_FFFF, 32'd30,        32'h0000_0001};
        tbl[8]  = '{SRA, 32'h8000_0000, 32'd0,         32'h8000_0000};
        tbl[9]  = '{SRL, 32'h1234_5678, 32'd0,         32'h1234_5678};
        tbl[10] = '{SRL, 32'hFFFF_FFFF, 32'hFFFF_FFE0, 32'hFFFF_FFFF};
        for (int i = 0; i < MVL; i++) begin
            a_mem[i]  = '0;
            sh_mem[i] = '0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_sh_en", sh_en, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_wb_idx", wb_idx, 0);
        chk("rst_wb_data", wb_data, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // SRA single element: encoding, latency and done timing
        a_mem[0]  = 32'h8000_0000;
        sh_mem[0] = 32'd4;
        push_exp(SRA, 1, '1);
        send(SRA, 1, '1);
        @(negedge clk);
        chk("t1_rd_en", rd_en, 1);
        chk("t1_rd_idx", rd_idx, 0);
        chk("t1_sh_en", sh_en, 1);
        chk("t1_sh_shift", sh_shift, 32'hFFFF_FFFC);
        chk("t1_dir_sel", sh_dir_sel, 1);
        chk("t1_data_tc", sh_data_tc, 1);
        chk("t1_wb_valid_early", wb_valid, 0);
        @(negedge clk);
        chk("t2_wb_valid", wb_valid, 1);
        chk("t2_wb_data", wb_data, 32'hF800_0000);
        chk("t2_done_early", done, 0);
        @(negedge clk);
        chk("t3_done", done, 1);
        chk("t3_err", err, 0);
        @(negedge clk);
        chk("t4_done_clear", done, 0);
        chk("t4_req_ready", req_ready, 1);

        // Single-element vector table
        for (int i = 0; i < 11; i++) begin
            a_mem[0]  = tbl[i].a;
            sh_mem[0] = tbl[i].sh;
            sb.push_back('{idx: '0, data: tbl[i].exp});
            d0 = done_cnt;
            send(tbl[i].op, 1, '1);
            wait_done("tbl_done");
            chk("tbl_done_cnt", 32'(done_cnt - d0), 1);
        end
        chk("tbl_sb_empty", 32'(sb.size()), 0);

        // SLL vl=4 back-to-back
        for (int i = 0; i < 4; i++) a_mem[i] = 32'h1;
        sh_mem[0] = 32'd0; sh_mem[1] = 32'd1; sh_mem[2] = 32'd33; sh_mem[3] = 32'd31;
        push_exp(SLL, 4, '1);
        send(SLL, 4, '1);
        @(negedge clk);
        chk("sll4_rd_en", rd_en, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("sll4_wb_valid", wb_valid, 1);
            chk("sll4_wb_idx", wb_idx, k);
        end
        wait_done("sll4_done");
        chk("sll4_sb_empty", 32'(sb.size()), 0);

        // SRL vl=3 with 3-cycle stall on element 1
        a_mem[0] = 32'hF000_0000; a_mem[1] = 32'h8000_0001; a_mem[2] = 32'h0000_FFFF;
        sh_mem[0] = 32'd4; sh_mem[1] = 32'd1; sh_mem[2] = 32'd8;
        a0 = acc_cnt;
        push_exp(SRL, 3, '1);
        send(SRL, 3, '1);
        @(posedge clk);
        @(posedge clk);
        #1 wb_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_wb_idx", wb_idx, 1);
            chk("stall_wb_data", wb_data, 32'h4000_0000);
        end
        @(posedge clk);
        #1 wb_ready = 1'b1;
        wait_done("stall_done");
        chk("stall_acc_cnt", 32'(acc_cnt - a0), 3);
        chk("stall_sb_empty", 32'(sb.size()), 0);

        // vl=0 and reserved op
        a0 = acc_cnt;
        e0 = err_cnt;
        send(SLL, 0, '1);
        @(negedge clk);
        chk("vl0_done", done, 1);
        chk("vl0_err", err, 0);
        chk("vl0_rd_en", rd_en, 0);
        @(negedge clk);
        chk("vl0_req_ready", req_ready, 1);
        send(RSV, 4, '1);
        @(negedge clk);
        chk("rsv_done", done, 1);
        chk("rsv_err", err, 1);
        chk("rsv_rd_en", rd_en, 0);
        @(negedge clk);
        chk("rsv_err_clear", err, 0);
        chk("rsv_req_ready", req_ready, 1);
        chk("rsv_no_wb", 32'(acc_cnt - a0), 0);
        chk("rsv_err_cnt", 32'(err_cnt - e0), 1);

        // Reset mid-RUN of vl=8
        for (int i = 0; i < 8; i++) begin
            a_mem[i]  = 32'h8000_0000 >> i;
            sh_mem[i] = 32'(i);
        end
        d0 = done_cnt;
        push_exp(SRA, 8, '1);
        send(SRA, 8, '1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_wb_valid", wb_valid, 0);
        chk("mid_rst_rd_en", rd_en, 0);
        chk("mid_rst_sh_en", sh_en, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_req_ready", req_ready, 1);
        chk("mid_rst_wb_data", wb_data, 0);
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("mid_rst_no_done", 32'(done_cnt - d0), 0);
        a0 = acc_cnt;
        push_exp(SLL, 2, '1);
        send(SLL, 2, '1);
        wait_done("post_rst_done");
        chk("post_rst_acc", 32'(acc_cnt - a0), 2);
        chk("post_rst_sb_empty", 32'(sb.size()), 0);

        // Full-length SRA with random backpressure
        for (int i = 0; i < MVL; i++) begin
            a_mem[i]  = $urandom;
            sh_mem[i] = $urandom;
        end
        d0 = done_cnt;
        a0 = acc_cnt;
        push_exp(SRA, MVL, '1);
        send(SRA, MVL, '1);
        for (int k = 0; k < 300 && done_cnt == d0; k++) begin
            @(posedge clk);
            #1 wb_ready = 1'($urandom_range(0, 1));
        end
        wb_ready = 1'b1;
        chk("rand_done", 32'(done_cnt - d0), 1);
        chk("rand_acc", 32'(acc_cnt - a0), MVL);
        chk("rand_sb_empty", 32'(sb.size()), 0);

`ifdef VSHIFT_MASK_EN
        // Masked elements
        for (int i = 0; i < 4; i++) begin
            a_mem[i]  = 32'h1 << i;
            sh_mem[i] = 32'd2;
        end
        a0 = acc_cnt;
        push_exp(SLL, 4, 16'b1010);
        send(SLL, 4, 16'b1010);
        wait_done("mask_done");
        chk("mask_acc", 32'(acc_cnt - a0), 2);
        chk("mask_done_after_last", 32'(done_cyc), 32'(last_acc_cyc + 1));
        chk("mask_sb_empty", 32'(sb.size()), 0);
        a0 = acc_cnt;
        send(SLL, 4, 16'b0);
        wait_done("mask0_done");
        chk("mask0_no_wb", 32'(acc_cnt - a0), 0);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
